// File: rtl/axis_pld_fifo.sv
// First-word-fall-through FIFO for packed AXIS payload words; optional store-and-forward by packet.
// Write-to-output latency is one cycle. in_ready drops only when full, with no write-through.
module axis_pld_fifo #(
  parameter int WIDTH_TDATA = 32,
  parameter int WIDTH_TUSER = 0,
  parameter int WIDTH_TID   = 0,
  parameter int WIDTH_TKEEP = 0,
  parameter int DEPTH       = 16,
  parameter int PACKET_MODE = 0,
  localparam int PAYLOAD_WIDTH = WIDTH_TDATA + 1 + WIDTH_TUSER + WIDTH_TID + WIDTH_TKEEP,
  localparam int LAST_BIT      = WIDTH_TUSER + WIDTH_TID + WIDTH_TKEEP,
  localparam int AW            = $clog2(DEPTH)
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [PAYLOAD_WIDTH-1:0] in_payload,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [PAYLOAD_WIDTH-1:0] out_payload,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW:0]              level,
  output logic [AW:0]              pkt_count
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [PAYLOAD_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [AW:0]              level_q, level_d;
  logic [AW:0]              pkt_q, pkt_d;
  logic                     drain_q, drain_d;
  logic                     rst_done_q;
  logic                     wr_en, rd_en, in_last, out_last;

  assign in_ready    = rst_done_q && (level_q != FULL_LVL);
  assign out_payload = mem_q[rd_ptr_q];
  assign wr_en       = in_valid && in_ready;
  assign rd_en       = out_valid && out_ready;
  assign in_last     = in_payload[LAST_BIT];
  assign out_last    = out_payload[LAST_BIT];
  assign level       = level_q;
  assign pkt_count   = pkt_q;

  generate
    if (PACKET_MODE != 0) begin : g_pkt
      // A full FIFO with no tail stored can never complete a packet, so it is released and drained.
      assign out_valid = (level_q != '0) &&
                         ((pkt_q != '0) || drain_q || (level_q == FULL_LVL));
    end else begin : g_plain
      assign out_valid = (level_q != '0);
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    drain_d  = drain_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_en, rd_en})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
    case ({wr_en && in_last, rd_en && out_last})
      2'b10:   pkt_d = pkt_q + (AW+1)'(1);
      2'b01:   pkt_d = pkt_q - (AW+1)'(1);
      default: pkt_d = pkt_q;
    endcase
    if (rd_en) begin
      if (out_last)          drain_d = 1'b0;
      else if (pkt_q == '0)  drain_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_q      <= '0;
      drain_q    <= 1'b0;
      rst_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_q      <= pkt_d;
      drain_q    <= drain_d;
      rst_done_q <= 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_payload;
  end

endmodule

// File: tb/tb_axis_pld_fifo.sv
// Directed bench for axis_pld_fifo: plain, packet and oversize-packet instances with a payload scoreboard.
module tb_axis_pld_fifo;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  // plain FIFO, DEPTH=4, payload {tdata[7:0], tlast}
  logic [8:0]  b_in_payload, b_out_payload;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [2:0]  b_level, b_pkt_count;
  // packet mode, DEPTH=8, payload {tdata[7:0], tlast, tuser[1:0], tkeep}
  logic [11:0] p_in_payload, p_out_payload;
  logic        p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [3:0]  p_level, p_pkt_count;
  // packet mode, DEPTH=4, payload {tdata[7:0], tlast}
  logic [8:0]  o_in_payload, o_out_payload;
  logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready;
  logic [2:0]  o_level, o_pkt_count;

  axis_pld_fifo #(.WIDTH_TDATA(8), .WIDTH_TUSER(0), .WIDTH_TID(0), .WIDTH_TKEEP(0),
                  .DEPTH(4), .PACKET_MODE(0)) u_basic (
    .aclk(aclk), .aresetn(aresetn),
    .in_payload(b_in_payload), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_payload(b_out_payload), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .level(b_level), .pkt_count(b_pkt_count));

  axis_pld_fifo #(.WIDTH_TDATA(8), .WIDTH_TUSER(2), .WIDTH_TID(0), .WIDTH_TKEEP(1),
                  .DEPTH(8), .PACKET_MODE(1)) u_pkt (
    .aclk(aclk), .aresetn(aresetn),
    .in_payload(p_in_payload), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .out_payload(p_out_payload), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .level(p_level), .pkt_count(p_pkt_count));

  axis_pld_fifo #(.WIDTH_TDATA(8), .WIDTH_TUSER(0), .WIDTH_TID(0), .WIDTH_TKEEP(0),
                  .DEPTH(4), .PACKET_MODE(1)) u_ovr (
    .aclk(aclk), .aresetn(aresetn),
    .in_payload(o_in_payload), .in_valid(o_in_valid), .in_ready(o_in_ready),
    .out_payload(o_out_payload), .out_valid(o_out_valid), .out_ready(o_out_ready),
    .level(o_level), .pkt_count(o_pkt_count));

  logic [8:0]  b_q[$];
  logic [11:0] p_q[$];
  logic [8:0]  o_q[$];
  logic        b_wr_fire, b_rd_fire, p_wr_fire, p_rd_fire, o_wr_fire, o_rd_fire;
  logic        b_hold;
  logic [8:0]  b_hold_pld;
  int          b_rcvd;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed time limit expired, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] bw(input logic [7:0] d, input logic l);
    return {d, l};
  endfunction

  function automatic logic [11:0] pw(input logic [7:0] d, input logic l,
                                     input logic [1:0] u, input logic k);
    return {d, l, u, k};
  endfunction

  // Samples handshakes at the falling edge (they commit on the next rising edge),
  // runs the scoreboards, then returns 1 time unit after the rising edge.
  task automatic tick();
    @(negedge aclk);
    if (b_hold) begin
      chk("b_stable_vld", b_out_valid, 1);
      chk("b_stable_pld", b_out_payload, b_hold_pld);
    end
    b_hold     = b_out_valid && !b_out_ready;
    b_hold_pld = b_out_payload;
    b_wr_fire = b_in_valid && b_in_ready;
    b_rd_fire = b_out_valid && b_out_ready;
    p_wr_fire = p_in_valid && p_in_ready;
    p_rd_fire = p_out_valid && p_out_ready;
    o_wr_fire = o_in_valid && o_in_ready;
    o_rd_fire = o_out_valid && o_out_ready;
    if (b_rd_fire) begin
      b_rcvd++;
      if (b_q.size() == 0) chk("b_underflow", b_q.size(), 1);
      else chk("b_data", b_out_payload, b_q.pop_front());
    end
    if (p_rd_fire) begin
      if (p_q.size() == 0) chk("p_underflow", p_q.size(), 1);
      else chk("p_data", p_out_payload, p_q.pop_front());
    end
    if (o_rd_fire) begin
      if (o_q.size() == 0) chk("o_underflow", o_q.size(), 1);
      else chk("o_data", o_out_payload, o_q.pop_front());
    end
    if (b_wr_fire) b_q.push_back(b_in_payload);
    if (p_wr_fire) p_q.push_back(p_in_payload);
    if (o_wr_fire) o_q.push_back(o_in_payload);
    @(posedge aclk);
    #1;
  endtask

  function automatic int b_q_lasts();
    int n = 0;
    foreach (b_q[i]) if (b_q[i][0]) n++;
    return n;
  endfunction

  initial begin
    int n;
    int sent;
    aresetn = 1'b0;
    b_in_valid = 0; b_out_ready = 0; b_in_payload = '0;
    p_in_valid = 0; p_out_ready = 0; p_in_payload = '0;
    o_in_valid = 0; o_out_ready = 0; o_in_payload = '0;
    b_hold = 0; b_hold_pld = '0; b_rcvd = 0;
    b_wr_fire = 0; b_rd_fire = 0; p_wr_fire = 0; p_rd_fire = 0; o_wr_fire = 0; o_rd_fire = 0;

    // reset state
    #2;
    chk("rst_in_ready", b_in_ready, 0);
    chk("rst_out_valid", b_out_valid, 0);
    chk("rst_level", b_level, 0);
    tick(); tick();
    aresetn = 1'b1;
    chk("rel_in_ready_pre", b_in_ready, 0);
    tick();
    chk("rel_in_ready", b_in_ready, 1);
    chk("rel_p_in_ready", p_in_ready, 1);
    chk("rel_o_in_ready", o_in_ready, 1);
    chk("rel_level", b_level, 0);
    chk("rel_pkt_count", b_pkt_count, 0);
    chk("rel_out_valid", b_out_valid, 0);

    // basic: three words, fall-through latency of one cycle
    b_in_valid = 1; b_in_payload = bw(8'h11, 0);
    tick();
    chk("b_latency", b_out_valid, 1);
    b_in_payload = bw(8'h22, 0); tick();
    b_in_payload = bw(8'h33, 0); tick();
    b_in_valid = 0;
    chk("b_level3", b_level, 3);
    chk("b_vld3", b_out_valid, 1);
    chk("b_head", b_out_payload, bw(8'h11, 0));
    b_out_ready = 1;
    repeat (3) tick();
    chk("b_empty_level", b_level, 0);
    chk("b_empty_vld", b_out_valid, 0);
    chk("b_empty_q", b_q.size(), 0);

    // full: simultaneous read and write request when full reads only
    b_out_ready = 0; b_in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b_in_payload = bw(8'h40 + 8'(i), i == 3);
      tick();
    end
    chk("f_in_ready", b_in_ready, 0);
    chk("f_level", b_level, 4);
    chk("f_pkt", b_pkt_count, 1);
    b_in_payload = bw(8'h50, 0); b_out_ready = 1;
    tick();
    chk("f_rd_only_level", b_level, 3);
    chk("f_rd_only_q", b_q.size(), 3);
    chk("f_in_ready_back", b_in_ready, 1);
    b_out_ready = 0;
    tick();
    chk("f_write_lands", b_level, 4);
    b_in_valid = 0; b_out_ready = 1;
    repeat (4) tick();
    chk("f_drained", b_level, 0);
    chk("f_drained_pkt", b_pkt_count, 0);
    chk("f_drained_q", b_q.size(), 0);
    b_out_ready = 0;

    // packet mode: output held until the tail is stored
    p_out_ready = 1; p_in_valid = 1;
    p_in_payload = pw(8'hA1, 0, 2'b01, 1); tick();
    chk("p_hold0", p_out_valid, 0);
    p_in_payload = pw(8'hA2, 0, 2'b11, 0); tick();
    chk("p_hold1", p_out_valid, 0);
    p_in_payload = pw(8'hA3, 1, 2'b10, 1); tick();
    p_in_valid = 0;
    chk("p_release", p_out_valid, 1);
    chk("p_pkt1", p_pkt_count, 1);
    chk("p_level3", p_level, 3);
    chk("p_head", p_out_payload, pw(8'hA1, 0, 2'b01, 1));
    tick(); tick();
    chk("p_pkt_still1", p_pkt_count, 1);
    tick();
    chk("p_pkt0", p_pkt_count, 0);
    chk("p_level0", p_level, 0);
    chk("p_q_empty", p_q.size(), 0);
    p_out_ready = 0;

    // oversize packet: released when full, drained to its tail
    o_out_ready = 1; o_in_valid = 1;
    for (int k = 1; k <= 6; k++) begin
      o_in_payload = bw(8'h60 + 8'(k), k == 6);
      if (k == 5) begin
        tick();
        chk("o_full_no_wr", o_wr_fire, 0);
        chk("o_drain_level", o_level, 3);
        chk("o_drain_vld", o_out_valid, 1);
      end
      n = 0;
      do begin tick(); n++; end while (!o_wr_fire && n < 10);
      chk("o_wr_timeout", o_wr_fire, 1);
      if (k <= 3) chk("o_held", o_out_valid, 0);
      if (k == 4) begin
        chk("o_full_vld", o_out_valid, 1);
        chk("o_full_level", o_level, 4);
      end
    end
    o_in_valid = 0;
    n = 0;
    while (o_q.size() != 0 && n < 20) begin tick(); n++; end
    chk("o_all_out", o_q.size(), 0);
    chk("o_level0", o_level, 0);
    chk("o_pkt0", o_pkt_count, 0);
    o_in_valid = 1; o_in_payload = bw(8'h70, 0); tick();
    o_in_valid = 0; tick();
    chk("o_drain_cleared", o_out_valid, 0);
    chk("o_level1", o_level, 1);
    o_in_valid = 1; o_in_payload = bw(8'h71, 1); tick();
    o_in_valid = 0;
    chk("o_tail_release", o_out_valid, 1);
    n = 0;
    while (o_q.size() != 0 && n < 10) begin tick(); n++; end
    chk("o_tail_out", o_q.size(), 0);
    o_out_ready = 0;

    // wrap-around with random valid/ready
    sent = 0; b_rcvd = 0; n = 0;
    while ((sent < 1000 || b_q.size() != 0) && n < 20000) begin
      b_in_valid   = (sent < 1000) && ($urandom_range(0, 1) == 1);
      b_in_payload = bw(8'(sent), 1'($urandom_range(0, 1)));
      b_out_ready  = ($urandom_range(0, 1) == 1);
      tick();
      if (b_wr_fire) sent++;
      chk("w_level_model", b_level, b_q.size());
      chk("w_pkt_model", b_pkt_count, b_q_lasts());
      chk("w_level_max", b_level <= 4, 1);
      n++;
    end
    b_in_valid = 0; b_out_ready = 0;
    chk("w_sent", sent, 1000);
    chk("w_rcvd", b_rcvd, 1000);

    // reset mid-operation discards stored words
    b_in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      b_in_payload = bw(8'h80 + 8'(i), i == 2);
      tick();
    end
    b_in_valid = 0;
    chk("r_level3", b_level, 3);
    #2 aresetn = 1'b0;
    #1;
    chk("r_vld_async", b_out_valid, 0);
    chk("r_in_ready_async", b_in_ready, 0);
    b_q.delete(); p_q.delete(); o_q.delete();
    b_hold = 0;
    #3 aresetn = 1'b1;
    tick();
    chk("r_level0", b_level, 0);
    chk("r_pkt0", b_pkt_count, 0);
    chk("r_in_ready", b_in_ready, 1);
    chk("r_vld", b_out_valid, 0);
    b_rcvd = 0; b_out_ready = 1;
    repeat (3) tick();
    chk("r_no_reappear_vld", b_out_valid, 0);
    chk("r_no_reappear_rd", b_rcvd, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axis_pld_fifo.md
Name: axis_pld_fifo

Overview:
- Synchronous FIFO that buffers packed AXI-Stream payload words between the AXIS-to-payload packer and the payload-to-AXIS unpacker.
- Stores the flat payload {tdata, tlast, tuser, tid, tkeep} unchanged, using the same field order and widths as the packer and unpacker.
- Optional packet mode holds output back until a complete packet, ending in a word with tlast=1, is stored.

Parameters:
- WIDTH_TDATA, 32, tdata width in bits (>=1)
- WIDTH_TUSER, 0, tuser width in bits (0 = field absent)
- WIDTH_TID, 0, tid width in bits (0 = field absent)
- WIDTH_TKEEP, 0, tkeep width in bits (0 = field absent)
- DEPTH, 16, number of entries; must be a power of 2 and >=2
- PACKET_MODE, 0, 0 = plain FIFO, 1 = store-and-forward by packet
- Derived localparams:
  - PAYLOAD_WIDTH = WIDTH_TDATA+1+WIDTH_TUSER+WIDTH_TID+WIDTH_TKEEP
  - LAST_BIT = WIDTH_TUSER+WIDTH_TID+WIDTH_TKEEP
  - AW = $clog2(DEPTH)

Ports:
- aclk  in  1  clock; single clock domain
- aresetn  in  1  asynchronous active-low reset
- in_payload  in  PAYLOAD_WIDTH  packed write word; tlast at bit LAST_BIT
- in_valid  in  1  write request
- in_ready  out  1  FIFO can accept a word
- out_payload  out  PAYLOAD_WIDTH  head-of-FIFO word
- out_valid  out  1  head word is presentable
- out_ready  in  1  downstream accepts the head word
- level  out  AW+1  number of stored words
- pkt_count  out  AW+1  number of stored words with tlast=1

Behaviour:
- Reset:
  - Asynchronous assert, synchronous release.
  - Pointers, level, pkt_count and the drain flag clear to 0.
  - out_valid=0, in_ready=1 (in_ready is gated by reset state, so it reads 0 while aresetn=0, then 1 from the first clock after release).
  - out_payload is don't-care while out_valid=0.
  - Reset mid-operation discards all contents, including any partial packet; no word may reappear after release.
- Write:
  - Occurs on a rising edge with in_valid && in_ready.
  - in_ready = (level != DEPTH).
  - When full, in_ready=0 even if a read occurs in the same cycle; there is no write-through when full.
- Read:
  - Occurs on a rising edge with out_valid && out_ready.
  - First-word-fall-through: out_payload always shows the entry at the read pointer.
  - out_payload and out_valid may be combinational from the registered state; no combinational path from in_* to out_* is allowed.
- Latency: a word written at edge N is visible with out_valid=1 after edge N (cycle N+1) when not held by packet mode.
- Pointers: AW-bit wrap-around. level updates +1 on write only, -1 on read only, unchanged on both.
- pkt_count:
  - +1 on a write with in_payload[LAST_BIT]=1.
  - -1 on a read with out_payload[LAST_BIT]=1.
  - Unchanged when both happen in the same cycle.
  - Tracked in both modes.
- PACKET_MODE=0: out_valid = (level != 0).
- PACKET_MODE=1:
  - out_valid = (level != 0) && (pkt_count != 0 || drain || level == DEPTH).
  - Oversize fallback: if the FIFO fills with no tlast stored, output is released.
    - The drain flag is set on any read of a tlast=0 word while pkt_count==0.
    - The drain flag is cleared on a read of a tlast=1 word.
    - While drain=1, out_valid follows (level != 0) until the tail of that packet is read.
- AXIS rules:
  - Once out_valid=1, out_valid and out_payload stay stable until the word is accepted. Reset is the only exception.
  - in_valid may assert regardless of in_ready.
- Widths: no arithmetic on payload; bit-exact pass-through. The parameter combinations WIDTH_TUSER/TID/TKEEP=0 must all elaborate.

Test Plan:
- Basic mode, DEPTH=4, TDATA=8, other widths 0:
  - Write 0x11,0x22,0x33 with tlast=0 and out_ready=0 -> level=3, out_valid=1, out_payload={0x11,0}.
  - Set out_ready=1 -> words read 0x11,0x22,0x33 in order, then level=0 and out_valid=0.
- Full/simultaneous, DEPTH=4:
  - Fill 4 words -> in_ready=0.
  - Hold in_valid=1 and out_ready=1 for one cycle -> exactly one read and no write, level=3.
  - Next cycle in_ready=1 and the write lands.
- Packet mode, DEPTH=8, TUSER=2, TKEEP=1:
  - Write 3 words, last has tlast=1 and tuser=2'b10; the first two are written with out_ready=1 -> out_valid stays 0 until the cycle after the tlast word is written.
  - The 3 words then read intact (tuser, tkeep preserved), pkt_count goes 1->0.
- Oversize packet, DEPTH=4, PACKET_MODE=1:
  - Write 6 words, tlast only on word 6 -> out_valid=1 when level reaches 4, drain=1 after the first read.
  - All 6 words emerge in order; drain clears after word 6.
- Wrap-around, DEPTH=4, random in_valid/out_ready at 50% for 1000 words -> scoreboard shows no loss, duplication or reorder; level never exceeds 4.
- Reset mid-operation: with 3 words stored, pulse aresetn=0 asynchronously between edges -> out_valid=0 immediately; after release level=0, pkt_count=0, in_ready=1.
